// File: rtl/fp_pkg.sv
// Shared state type, width defaults and exponent helpers for the fp_addsub adder.
package fp_pkg;

  localparam int FP_EW = 5;
  localparam int FP_MW = 10;
  localparam int FP_GW = 3;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} fp_state_e;

  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic int fp_exp_ones(input int ew);
    return (1 << ew) - 1;
  endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational rounding stage for fp_addsub.
// Round-to-nearest-even when FP_ADDSUB_RNE_EN is defined, truncation otherwise.
module fp_round #(
  parameter int MW = 10
) (
  input  logic [MW:0] mant,
  input  logic        guard,
  input  logic        round,
  input  logic        sticky,
  input  logic        sign,
  output logic [MW:0] mant_rnd,
  output logic        carry
);

  logic inc;
  logic unused_ok;

`ifdef FP_ADDSUB_RNE_EN
  // Round up above half, or at exactly half when the kept LSB is odd.
  assign inc = guard & (round | sticky | mant[0]);
`else
  assign inc = 1'b0;
`endif

  assign {carry, mant_rnd} = {1'b0, mant} + {{(MW + 1){1'b0}}, inc};

  // Sign is irrelevant to both supported modes; bits are folded here on purpose.
  assign unused_ok = ^{sign, guard, round, sticky};

endmodule

// File: rtl/fp_addsub.sv
// Multi-cycle floating-point add/subtract: one-bit-per-cycle align and normalise.
// Rounding mode selected by macro FP_ADDSUB_RNE_EN (RNE when defined, truncation otherwise).
module fp_addsub
  import fp_pkg::*;
#(
  parameter int EW = FP_EW,
  parameter int MW = FP_MW,
  parameter int GW = FP_GW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           st,
  input  logic           op,
  input  logic [EW+MW:0] a,
  input  logic [EW+MW:0] b,
  output logic           busy,
  output logic           done,
  output logic           ovf,
  output logic           unf,
  output logic [EW+MW:0] result
);

  localparam int             F         = MW + 1 + GW;
  localparam logic [EW-1:0]  MAX_SH    = EW'(MW + GW + 1);
  localparam logic [EW-1:0]  D_ONE     = EW'(1);
  localparam logic [EW:0]    E_ONE     = (EW + 1)'(1);
  localparam logic [EW:0]    EXP_LIMIT = (EW + 1)'(fp_exp_ones(EW));
  localparam logic [EW-1:0]  EXP_ONES  = '1;

  fp_state_e state, state_nx;

  logic                go, sx, sy, sinf, inf_r, sz, zero_r, unf_r;
  logic [EW:0]         ex;
  logic [EW-1:0]       d;
  logic [F-1:0]        mx, my, mm;

  // Operand decode; subnormals flush to zero, x always holds the larger exponent.
  logic [EW-1:0] ea, eb;
  logic          sb_eff, swap, ia, ib;
  logic [F-1:0]  ma_x, mb_x;

  assign ea     = a[EW+MW-1:MW];
  assign eb     = b[EW+MW-1:MW];
  assign sb_eff = b[EW+MW] ^ op;
  assign swap   = (eb > ea);
  assign ia     = (ea == EXP_ONES);
  assign ib     = (eb == EXP_ONES);
  assign ma_x   = (ea == '0) ? '0 : {1'b1, a[MW-1:0], {GW{1'b0}}};
  assign mb_x   = (eb == '0) ? '0 : {1'b1, b[MW-1:0], {GW{1'b0}}};

  // Signed sum of magnitudes; the sign of the sum is the sign of the larger operand.
  logic signed [F+1:0] opx, opy, sum_s, mag_full;
  logic [F:0]          sum_mag;
  logic                unused_msb;

  assign opx        = $signed({2'b00, mx});
  assign opy        = $signed({2'b00, my});
  assign sum_s      = (sx ? -opx : opx) + (sy ? -opy : opy);
  assign mag_full   = sum_s[F+1] ? -sum_s : sum_s;
  assign sum_mag    = mag_full[F:0];
  assign unused_msb = mag_full[F+1];

  logic [MW:0] mant_rnd;
  logic        rcarry;
  logic [EW:0] e_fin;

  fp_round #(.MW(MW)) u_round (
    .mant    (mm[F-1:GW]),
    .guard   (mm[GW-1]),
    .round   (mm[GW-2]),
    .sticky  (|mm[GW-3:0]),
    .sign    (sz),
    .mant_rnd(mant_rnd),
    .carry   (rcarry)
  );

  assign e_fin = ex + {{EW{1'b0}}, rcarry};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx = state;
    busy     = 1'b1;
    case (state)
      IDLE:    begin
                 busy = 1'b0;
                 if (go) state_nx = ALIGN;
               end
      ALIGN:   if (d == '0 || d > MAX_SH) state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    if (zero_r || mm[F-1] || ex == E_ONE) state_nx = ROUND;
      ROUND:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      go <= 1'b0;  sx <= 1'b0;  sy <= 1'b0;  sinf <= 1'b0;  inf_r <= 1'b0;
      sz <= 1'b0;  zero_r <= 1'b0;  unf_r <= 1'b0;
      ex <= '0;  d <= '0;  mx <= '0;  my <= '0;  mm <= '0;
      done <= 1'b0;  ovf <= 1'b0;  unf <= 1'b0;  result <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every register samples pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The accepting edge captures operands; the following edge launches ALIGN.
          if (go) begin
            go <= 1'b0;
          end else if (st) begin
            go     <= 1'b1;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            zero_r <= 1'b0;
            unf_r  <= 1'b0;
            inf_r  <= ia | ib;
            sinf   <= ia ? a[EW+MW] : sb_eff;
            d      <= swap ? eb - ea : ea - eb;
            if (swap) begin
              sx <= sb_eff;    ex <= {1'b0, eb};  mx <= mb_x;
              sy <= a[EW+MW];  my <= ma_x;
            end else begin
              sx <= a[EW+MW];  ex <= {1'b0, ea};  mx <= ma_x;
              sy <= sb_eff;    my <= mb_x;
            end
          end
        end
        ALIGN: begin
          // Bit 0 of my is the sticky position and accumulates everything shifted past it.
          if (d > MAX_SH) begin
            my <= {{(F - 1){1'b0}}, |my};
            d  <= '0;
          end else if (d != '0) begin
            my <= {1'b0, my[F-1:2], my[1] | my[0]};
            d  <= d - D_ONE;
          end
        end
        ADD: begin
          sz     <= sum_s[F+1];
          zero_r <= (sum_mag == '0);
          if (sum_mag[F]) begin
            mm <= {sum_mag[F:2], sum_mag[1] | sum_mag[0]};
            ex <= ex + E_ONE;
          end else begin
            mm <= sum_mag[F-1:0];
          end
        end
        NORM: begin
          if (!zero_r && !mm[F-1]) begin
            if (ex == E_ONE) unf_r <= 1'b1;
            else begin
              mm <= {mm[F-2:0], 1'b0};
              ex <= ex - E_ONE;
            end
          end
        end
        ROUND: begin
          done <= 1'b1;
          if (inf_r) begin
            result <= {sinf, EXP_ONES, {MW{1'b0}}};
            ovf    <= 1'b1;
          end else if (zero_r) begin
            result <= '0;
          end else if (unf_r) begin
            result <= {sz, {(EW + MW){1'b0}}};
            unf    <= 1'b1;
          end else if (e_fin >= EXP_LIMIT) begin
            result <= {sz, EXP_ONES, {MW{1'b0}}};
            ovf    <= 1'b1;
          end else begin
            result <= {sz, e_fin[EW-1:0], mant_rnd[MW-1:0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_addsub.md
FP_ADDSUB -- requirements
Module: fp_addsub

Interface
REQ-001 SHALL have parameter EW, default 5: exponent field width.
REQ-002 SHALL have parameter MW, default 10: stored mantissa width (hidden bit implicit).
REQ-003 SHALL have parameter GW, default 3: extra datapath bits below the LSB (guard, round, sticky).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port st  input  1  start; sampled only in IDLE.
REQ-007 SHALL have port op  input  1  0 = a+b, 1 = a-b; captured with st.
REQ-008 SHALL have ports a, b  input  1+EW+MW  operands as {sign, biased exp, mantissa}; captured with st.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-011 SHALL have ports ovf, unf  output  1  exponent overflow / underflow flags; valid with done.
REQ-012 SHALL have port result  output  1+EW+MW  sum; holds until the next done.

Function
REQ-013 SHALL use bias 2^(EW-1)-1; exp=0 means zero (subnormal inputs flushed to zero); exp=all-ones input treated as overflow.
REQ-014 SHALL run FSM IDLE->ALIGN->ADD->NORM->ROUND->IDLE; an st seen in IDLE moves to ALIGN on the next edge; st is ignored while busy.
REQ-015 ALIGN SHALL right-shift the smaller-exponent mantissa by one bit per cycle, OR-ing shifted-out bits into sticky, until exponents are equal.
REQ-016 ALIGN SHALL early-exit when exponent difference > MW+GW+1: the smaller operand collapses to sticky only, and the FSM goes to ADD next cycle.
REQ-017 ADD SHALL form a signed sum of magnitudes (b sign inverted when op=1); result sign = sign of the larger magnitude.
REQ-018 On carry-out, ADD SHALL shift right 1 bit, keep sticky, and increment the exponent.
REQ-019 NORM SHALL left-shift 1 bit per cycle, decrementing the exponent, until the hidden bit is 1.
REQ-020 A zero sum SHALL produce +0, skip NORM shifting, and raise no flags.
REQ-021 ROUND SHALL apply the rounding mode (REQ-029/030); a mantissa carry from rounding SHALL increment the exponent.
REQ-022 If the final biased exponent >= 2^EW-1: ovf=1, result = {sign, all-ones, zeros}.
REQ-023 If the biased exponent falls below 1 in NORM: unf=1, result = {sign, zeros}, and NORM exits immediately.
REQ-024 done, result and flags SHALL update on the ROUND-exit edge; flags SHALL clear at the next accepted st.
REQ-025 A zero operand SHALL pass the other operand through, sign-corrected for op; total latency is unchanged.

Reset
REQ-026 reset low SHALL immediately force IDLE, busy=0, done=0, ovf=0, unf=0, result=0, and clear internal registers.
REQ-027 Reset asserted mid-operation SHALL discard the operation with no done pulse.

Configuration
REQ-028 Rounding SHALL be selected by macro FP_ADDSUB_RNE_EN.
REQ-029 With FP_ADDSUB_RNE_EN defined: round-to-nearest-even using guard, round and sticky.
REQ-030 Without FP_ADDSUB_RNE_EN: truncation; ROUND state is still present, so latency is identical in both builds.

Structure
REQ-031 Package fp_pkg SHALL hold the state enum, the bias/all-ones exponent functions of EW, and the width localparams.
REQ-032 Combinational sub-module fp_round (inputs: mantissa, guard/round/sticky, sign; outputs: rounded mantissa, carry) SHALL be instantiated in ROUND.

Verification (EW=5, MW=10, GW=3)
REQ-033 0x3C00 + 0x3C00, op=0 -> result 0x4000, flags 0, done on the 5th edge after the st-sampling edge.
REQ-034 0x3C00 - 0x3C00, op=1 -> result 0x0000, ovf=0, unf=0.
REQ-035 0x7BFF + 0x7BFF -> ovf=1, result 0x7C00.
REQ-036 0x3C01 + 0x1000 -> result 0x3C02 with FP_ADDSUB_RNE_EN, 0x3C01 without.
REQ-037 0x0401 - 0x0400, op=1 -> unf=1, result 0x0000.
REQ-038 reset low during ALIGN of 0x3C00 + 0x2000 -> busy=0 at once, no done pulse; a following st completes normally.
